// File: rtl/rgb_frame_sink_if.sv
// Bundle for rgb_frame_sink: the pixel input from the pipeline, the tagged
// valid/ready output stream, and the FIFO/frame status signals.
interface rgb_frame_sink_if #(
   parameter int ADDR_WIDTH = 6
);
   // pixel input from the processing pipeline (no backpressure)
   logic                new_frame;
   logic                pix_valid;
   logic [7:0]          r;
   logic [7:0]          g;
   logic [7:0]          b;

   // tagged output stream
   logic [23:0]         data;
   logic [15:0]         x;
   logic [15:0]         y;
   logic                sof;
   logic                eol;
   logic                eof;
   logic                valid;
   logic                ready;

   // status
   logic [ADDR_WIDTH:0] level;
   logic                overflow;
   logic                frame_err;
   logic                frame_done;
   logic [15:0]         frame_cnt;

   modport master (
      output new_frame, pix_valid, r, g, b, ready,
      input  data, x, y, sof, eol, eof, valid,
      input  level, overflow, frame_err, frame_done, frame_cnt
   );

   modport slave (
      input  new_frame, pix_valid, r, g, b, ready,
      output data, x, y, sof, eol, eof, valid,
      output level, overflow, frame_err, frame_done, frame_cnt
   );
endinterface

// File: rtl/rgb_frame_sink.sv
// Frame sink: tags incoming RGB pixels with raster position and frame flags,
// buffers them in a FIFO and presents them on a registered valid/ready stream.
module rgb_frame_sink #(
   parameter int WIDTH      = 320,
   parameter int HEIGHT     = 240,
   parameter int FIFO_DEPTH = 64,
   parameter int ADDR_WIDTH = 6
) (
   input logic             clk,
   input logic             reset,
   rgb_frame_sink_if.slave bus
);

   typedef enum logic {
      IDLE,
      ACTIVE
   } state_t;

   typedef struct packed {
      logic [23:0] data;
      logic [15:0] x;
      logic [15:0] y;
      logic        sof;
      logic        eol;
      logic        eof;
   } entry_t;

   localparam logic [15:0]         X_LAST  = 16'(WIDTH - 1);
   localparam logic [15:0]         Y_LAST  = 16'(HEIGHT - 1);
   localparam logic [ADDR_WIDTH:0] LVL_MAX = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

   // write side
   state_t          state_q, state_d;
   logic [15:0]     x_q, x_d;
   logic [15:0]     y_q, y_d;
   logic [15:0]     cur_x, cur_y;
   logic            err_set;
   logic            wr_en;
   logic            drop;
   entry_t          wr_entry;

   // storage and read side
   entry_t                mem [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q;
   logic [ADDR_WIDTH-1:0] rd_ptr_q;
   logic [ADDR_WIDTH:0]   level_q;
   logic [ADDR_WIDTH:0]   mem_cnt;
   logic                  full;
   logic                  xfer;
   logic                  load;
   entry_t                out_q;
   logic                  out_valid_q;

   // status
   logic                  overflow_q;
   logic                  frame_err_q;
   logic                  frame_done_q;
   logic [15:0]           frame_cnt_q;

   assign xfer    = out_valid_q && bus.ready;
   assign full    = (level_q == LVL_MAX);
   // entries still in the array, i.e. not yet in the output register
   assign mem_cnt = level_q - {{ADDR_WIDTH{1'b0}}, out_valid_q};
   assign load    = (!out_valid_q || xfer) && (mem_cnt != '0);
   // a read in the same cycle frees a slot, so a full FIFO can still accept
   assign wr_en   = bus.pix_valid && (!full || xfer);
   assign drop    = bus.pix_valid && !wr_en;

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      cur_x    = x_q;
      cur_y    = y_q;
      err_set  = 1'b0;
      wr_entry = '0;

      // newFrame is applied before the pixel of the same cycle
      if (bus.new_frame) begin
         if (state_q == ACTIVE && (x_q != '0 || y_q != '0)) begin
            err_set = 1'b1;
            state_d = IDLE;
         end
         cur_x = '0;
         cur_y = '0;
      end

      x_d = cur_x;
      y_d = cur_y;

      wr_entry.data = {bus.r, bus.g, bus.b};
      wr_entry.x    = cur_x;
      wr_entry.y    = cur_y;
      wr_entry.sof  = (cur_x == '0) && (cur_y == '0);
      wr_entry.eol  = (cur_x == X_LAST);
      wr_entry.eof  = (cur_x == X_LAST) && (cur_y == Y_LAST);

      // dropped pixels leave the coordinates for the next accepted pixel
      if (wr_en) begin
         if (wr_entry.eof) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
         end else begin
            state_d = ACTIVE;
            if (wr_entry.eol) begin
               x_d = '0;
               y_d = cur_y + 16'd1;
            end else begin
               x_d = cur_x + 16'd1;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   // NOTE: the array is not reset; validity is tracked by the pointers and level.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= wr_entry;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         overflow_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (load)  rd_ptr_q <= rd_ptr_q + PTR_ONE;

         case ({wr_en, xfer})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase

         // the output register refills on the same edge it is emptied
         if (load) begin
            out_q       <= mem[rd_ptr_q];
            out_valid_q <= 1'b1;
         end else if (xfer) begin
            out_valid_q <= 1'b0;
         end

         frame_done_q <= xfer && out_q.eof;
         if (xfer && out_q.eof) frame_cnt_q <= frame_cnt_q + 16'd1;

         if (drop)    overflow_q  <= 1'b1;
         if (err_set) frame_err_q <= 1'b1;
      end
   end

   assign bus.data       = out_q.data;
   assign bus.x          = out_q.x;
   assign bus.y          = out_q.y;
   assign bus.sof        = out_q.sof;
   assign bus.eol        = out_q.eol;
   assign bus.eof        = out_q.eof;
   assign bus.valid      = out_valid_q;
   assign bus.level      = level_q;
   assign bus.overflow   = overflow_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.frame_done = frame_done_q;
   assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_rgb_frame_sink.sv
// Bench for rgb_frame_sink: directed scenarios plus random traffic, compared
// each cycle against a queue-based model of the tagged pixel stream.
module tb_rgb_frame_sink;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int D  = 8;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   rgb_frame_sink_if #(.ADDR_WIDTH(AW)) bus ();

   rgb_frame_sink #(
      .WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   typedef struct {
      logic [23:0] d;
      int          x;
      int          y;
      bit          sof;
      bit          eol;
      bit          eof;
      int          wc;
   } ent_t;

   // reference model: a queue of accepted pixels plus the frame position
   ent_t        q[$];
   int          pos;
   bit          m_ovf;
   bit          m_err;
   bit          m_done;
   logic [15:0] m_cnt;
   int          cyc;

   int checks;
   int errors;

   function automatic bit exp_valid();
      return (q.size() > 0) && (q[0].wc < cyc);
   endfunction

   function automatic logic [127:0] exp_snap();
      logic [127:0] s;
      s = '0;
      s[0]     = exp_valid();
      s[4:1]   = 4'(q.size());
      s[5]     = m_ovf;
      s[6]     = m_err;
      s[7]     = m_done;
      s[23:8]  = m_cnt;
      if (exp_valid()) begin
         s[47:24] = q[0].d;
         s[63:48] = 16'(q[0].x);
         s[79:64] = 16'(q[0].y);
         s[80]    = q[0].sof;
         s[81]    = q[0].eol;
         s[82]    = q[0].eof;
      end
      return s;
   endfunction

   function automatic logic [127:0] act_snap();
      logic [127:0] s;
      s = '0;
      s[0]     = bus.valid;
      s[4:1]   = bus.level;
      s[5]     = bus.overflow;
      s[6]     = bus.frame_err;
      s[7]     = bus.frame_done;
      s[23:8]  = bus.frame_cnt;
      if (bus.valid) begin
         s[47:24] = bus.data;
         s[63:48] = bus.x;
         s[79:64] = bus.y;
         s[80]    = bus.sof;
         s[81]    = bus.eol;
         s[82]    = bus.eof;
      end
      return s;
   endfunction

   task automatic drive(input bit nf, input bit v, input logic [23:0] d, input bit rdy);
      bus.new_frame = nf;
      bus.pix_valid = v;
      {bus.r, bus.g, bus.b} = d;
      bus.ready = rdy;
   endtask

   task automatic model_clear();
      q.delete();
      pos    = 0;
      m_ovf  = 1'b0;
      m_err  = 1'b0;
      m_done = 1'b0;
      m_cnt  = '0;
   endtask

   // advance the model by one clock using the currently driven inputs
   task automatic step();
      bit tr;
      bit acc;
      ent_t e;
      tr = exp_valid() && bus.ready;
      if (bus.new_frame) begin
         if (pos != 0) m_err = 1'b1;
         pos = 0;
      end
      acc = bus.pix_valid && ((q.size() < D) || tr);
      if (bus.pix_valid && !acc) m_ovf = 1'b1;
      m_done = tr && q[0].eof;
      if (m_done) m_cnt = m_cnt + 16'd1;
      if (tr) void'(q.pop_front());
      if (acc) begin
         e.d   = {bus.r, bus.g, bus.b};
         e.x   = pos % W;
         e.y   = pos / W;
         e.sof = (pos == 0);
         e.eol = ((pos % W) == W - 1);
         e.eof = (pos == W * H - 1);
         e.wc  = cyc + 1;
         q.push_back(e);
         pos = (pos + 1) % (W * H);
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 1'b0, 24'h0, 1'b0);
      @(posedge clk);
      cyc++;
      #1;
      reset = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 1'b0, 24'h0, 1'b0);
      repeat (2) @(posedge clk);
      cyc += 2;
      #1;
      reset = 1'b0;
      model_clear();
      checks++;
      if (act_snap() !== exp_snap()) begin
         errors++;
         $display("FAIL reset_state actual %h required %h", act_snap(), exp_snap());
      end
      checks++;
      if (bus.valid !== 1'b0 || bus.level !== '0) begin
         errors++;
         $display("FAIL reset_empty actual valid=%b level=%0d required valid=0 level=0",
                  bus.valid, bus.level);
      end
   endtask

   task automatic test_smoke();
      for (int i = 0; i < 11; i++) begin
         if (i < 8) drive(1'b0, 1'b1, 24'(i + 1), 1'b1);
         else       drive(1'b0, 1'b0, 24'h0, 1'b1);
         step();
         checks++;
         if (act_snap() !== exp_snap()) begin
            errors++;
            $display("FAIL smoke cyc %0d actual %h required %h", i, act_snap(), exp_snap());
         end
      end
      checks++;
      if (bus.frame_cnt !== 16'd1) begin
         errors++;
         $display("FAIL smoke_frame_cnt actual %0d required 1", bus.frame_cnt);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      // start mid-frame so the dropped pixel has non-zero coordinates
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, i < 2, 24'hA0 + 24'(i), 1'b1);
         step();
      end
      for (int i = 0; i < 9; i++) begin
         drive(1'b0, 1'b1, 24'hB0 + 24'(i), 1'b0);
         step();
         checks++;
         if (act_snap() !== exp_snap()) begin
            errors++;
            $display("FAIL backpressure_fill %0d actual %h required %h", i, act_snap(), exp_snap());
         end
      end
      checks++;
      if (bus.overflow !== 1'b1 || bus.level !== 4'd8 || bus.data !== 24'hB0) begin
         errors++;
         $display("FAIL backpressure_full actual ovf=%b level=%0d data=%h required ovf=1 level=8 data=0000b0",
                  bus.overflow, bus.level, bus.data);
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, i == 8, 24'hC0, 1'b1);
         step();
         checks++;
         if (act_snap() !== exp_snap()) begin
            errors++;
            $display("FAIL backpressure_drain %0d actual %h required %h", i, act_snap(), exp_snap());
         end
      end
   endtask

   task automatic test_full_read();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, 24'hD0 + 24'(i), 1'b0);
         step();
      end
      drive(1'b0, 1'b1, 24'hDF, 1'b1);
      step();
      checks++;
      if (act_snap() !== exp_snap()) begin
         errors++;
         $display("FAIL full_read actual %h required %h", act_snap(), exp_snap());
      end
      checks++;
      if (bus.level !== 4'd8 || bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_read_level actual level=%0d ovf=%b required level=8 ovf=0",
                  bus.level, bus.overflow);
      end
   endtask

   task automatic test_short_frame();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 24'hE0 + 24'(i), 1'b1);
         step();
      end
      drive(1'b1, 1'b0, 24'h0, 1'b1);
      step();
      drive(1'b0, 1'b1, 24'hEE, 1'b1);
      step();
      drive(1'b0, 1'b0, 24'h0, 1'b0);
      step();
      checks++;
      if (act_snap() !== exp_snap()) begin
         errors++;
         $display("FAIL short_frame actual %h required %h", act_snap(), exp_snap());
      end
      checks++;
      if (bus.frame_err !== 1'b1 || bus.sof !== 1'b1 || bus.x !== 16'd0 || bus.y !== 16'd0) begin
         errors++;
         $display("FAIL short_frame_tag actual err=%b sof=%b x=%0d y=%0d required err=1 sof=1 x=0 y=0",
                  bus.frame_err, bus.sof, bus.x, bus.y);
      end
   endtask

   task automatic test_nf_same_cycle();
      do_reset();
      drive(1'b1, 1'b1, 24'h123456, 1'b0);
      step();
      drive(1'b0, 1'b0, 24'h0, 1'b0);
      step();
      checks++;
      if (act_snap() !== exp_snap()) begin
         errors++;
         $display("FAIL nf_same_cycle actual %h required %h", act_snap(), exp_snap());
      end
      checks++;
      if (bus.frame_err !== 1'b0 || bus.sof !== 1'b1 || bus.data !== 24'h123456) begin
         errors++;
         $display("FAIL nf_same_cycle_tag actual err=%b sof=%b data=%h required err=0 sof=1 data=123456",
                  bus.frame_err, bus.sof, bus.data);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 24'hF0 + 24'(i), 1'b0);
         step();
      end
      drive(1'b1, 1'b0, 24'h0, 1'b0);
      step();
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b1, 24'hF8 + 24'(i), 1'b0);
         step();
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 24'h0, 1'b1);
         step();
      end
      checks++;
      if (act_snap() !== exp_snap() || bus.level !== 4'd5) begin
         errors++;
         $display("FAIL reset_mid_pre actual %h required %h", act_snap(), exp_snap());
      end
      do_reset();
      checks++;
      if (act_snap() !== exp_snap()) begin
         errors++;
         $display("FAIL reset_mid_post actual %h required %h", act_snap(), exp_snap());
      end
      drive(1'b0, 1'b1, 24'h777777, 1'b0);
      step();
      drive(1'b0, 1'b0, 24'h0, 1'b0);
      step();
      checks++;
      if (act_snap() !== exp_snap()) begin
         errors++;
         $display("FAIL reset_mid_pixel actual %h required %h", act_snap(), exp_snap());
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         drive(($urandom % 16) == 0, ($urandom % 4) != 0, 24'($urandom), ($urandom % 3) != 0);
         step();
         checks++;
         if (act_snap() !== exp_snap()) begin
            errors++;
            $display("FAIL random cyc %0d actual %h required %h", i, act_snap(), exp_snap());
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      model_clear();
      test_reset();
      test_smoke();
      test_backpressure();
      test_full_read();
      test_short_frame();
      test_nf_same_cycle();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rgb_frame_sink.md
Name: rgb_frame_sink

Overview:
- Downstream consumer of the pixel-processing pipeline's final RGB output (8-bit R/G/B plus a valid strobe, no backpressure).
- Buffers pixels in a FIFO and tags each with raster coordinates and start-of-frame / end-of-line / end-of-frame flags.
- Presents the pixels on a valid/ready stream to the display or memory writer.
- Reports overflow, short frames and completed frames.

Parameters:
- width, 320, active pixels per line
- height, 240, lines per frame
- fifoDepth, 64, FIFO entries; must be a power of 2, at least 4
- addrWidth, 6, log2(fifoDepth)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- newFrame  in  1  one-cycle pulse marking the start of a new input frame
- iValid  in  1  input pixel valid (the upstream oValidRGB)
- iR, iG, iB  in  8 each  input pixel components
- oData  out  24  {R,G,B} of the head pixel
- oX  out  16  column of the head pixel
- oY  out  16  row of the head pixel
- oSof  out  1  head pixel is (0,0)
- oEol  out  1  head pixel has x = width-1
- oEof  out  1  head pixel is (width-1, height-1)
- oValid  out  1  head pixel available
- iReady  in  1  downstream accepts; a transfer occurs when oValid && iReady
- oLevel  out  addrWidth+1  FIFO occupancy
- oOverflow  out  1  sticky: a pixel was dropped
- oFrameErr  out  1  sticky: newFrame arrived mid-frame
- oFrameDone  out  1  one-cycle pulse when the EOF pixel transfers
- oFrameCnt  out  16  number of completed frames transferred out; wraps

Behaviour:
- Reset: all outputs 0, FIFO empty, write coordinates (0,0), FSM in IDLE. Reset mid-frame discards the FIFO contents.
- Each FIFO entry is 24 data bits + 16-bit x + 16-bit y + 3 flag bits. Coordinates and flags are computed on the write side at write time.
- Write-side FSM:
  - IDLE → ACTIVE on the first accepted iValid.
  - ACTIVE → IDLE after the pixel at (width-1, height-1) is accepted.
  - x increments per accepted pixel. At width-1, x wraps to 0 and y increments. At (width-1, height-1), both wrap to 0.
  - newFrame in IDLE, or in ACTIVE with write coordinates at (0,0): no effect beyond clearing the coordinates.
  - newFrame in ACTIVE with coordinates not (0,0): set oFrameErr, force coordinates to (0,0), go to IDLE.
  - newFrame and iValid in the same cycle: newFrame is applied first, so the pixel is written as (0,0) with SOF.
- Write: accepted when iValid and (not full, or a read happens in the same cycle).
- Drop: iValid while full with no same-cycle read drops the pixel, sets oOverflow, and does not advance the coordinates. The next accepted pixel takes the dropped pixel's coordinates.
- Read: first-word-fall-through via a registered output stage.
  - A pixel written into an empty FIFO at edge N is on oData with oValid=1 after edge N+1 (one cycle of latency).
  - Output fields hold stable while oValid && !iReady.
  - On a transfer, the next entry appears the following cycle with no bubble when the FIFO is non-empty (full throughput of 1 pixel per clock).
- oLevel counts stored entries including the output register:
  - +1 on a write.
  - −1 on a transfer.
  - unchanged on a simultaneous write and transfer.
  - Range 0..fifoDepth; full means oLevel == fifoDepth.
- oFrameDone pulses in the cycle after a transfer with oEof=1, and oFrameCnt increments in that same cycle. It wraps 0xFFFF → 0.
- oOverflow and oFrameErr clear only on reset.
- Pointers wrap modulo fifoDepth. Empty and full are distinguished by the level count.

Test Plan:
- Smoke: width=4, height=2, fifoDepth=8, iReady=1, 8 consecutive pixels with values 0x000001..0x000008.
  - Outputs appear 1 cycle after each input.
  - Coordinates run (0,0)..(3,1).
  - oSof on the first pixel; oEol on x=3; oEof on the 8th.
  - oFrameDone pulses once; oFrameCnt=1.
- Backpressure: iReady=0 while writing 8 pixels.
  - oLevel=8, first pixel held stable.
  - A 9th iValid sets oOverflow=1 with oLevel still 8.
  - Raise iReady: 8 pixels drain in order on 8 consecutive cycles.
  - The next accepted pixel gets the dropped pixel's coordinates.
- Full with a simultaneous read: FIFO full, iReady=1, iValid=1 in the same cycle → write accepted, oLevel stays 8, oOverflow stays 0.
- Short frame: 3 pixels written, then newFrame → oFrameErr=1; the next pixel is tagged (0,0) with oSof=1.
- newFrame and iValid in the same cycle at idle → pixel tagged (0,0) with oSof=1, oFrameErr=0.
- Reset mid-stream with oLevel=5 → next cycle oValid=0, oLevel=0, sticky flags cleared, and a new pixel is tagged (0,0).
